i2s_frame_tx: RTL
=================

Name: i2s_frame_tx

Overview:
- Final output stage of the SuperMic chain; consumes the beamformed sum from the delay/adder path and drives a standard Philips I2S link (bit clock, LR clock, serial data) off-chip.
- Generates its own bclk/lr_clk from clk and buffers samples in a 2-entry FIFO with valid/ready handshake.
- Mono source: each sample is sent in both left and right slots, sign-extended to 32 bits.

Parameters:
- IN_W, 22, width of signed input sample.
- SLOT_W, 32, bits per I2S channel slot; IN_W <= SLOT_W.
- CLK_PER_BIT, 4, clk cycles per bclk period; even, >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (asserted = 0).
- s_data  input  IN_W  signed PCM sample.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept; equals !full.
- bclk  output  1  I2S bit clock.
- lr_clk  output  1  I2S word select; 0 = left slot, 1 = right slot.
- sd  output  1  I2S serial data, MSB first.
- frame_start  output  1  one-clk pulse when bit_idx wraps 63->0.
- underrun  output  1  one-clk pulse when a load finds the FIFO empty.

Behaviour:
- Reset (rst=0, async): cnt=0, bit_idx=0, bclk=0, lr_clk=0, sd=0, shift register=0, FIFO empty, frame_start=0, underrun=0, last-sample register=0. s_ready=1 while FIFO not full, including during reset.
- Divider: cnt counts 0..CLK_PER_BIT-1 and wraps. bclk=1 when cnt >= CLK_PER_BIT/2. tick = (cnt==CLK_PER_BIT-1), i.e. the bclk falling edge.
- On tick: bit_idx increments modulo 2*SLOT_W (64). lr_clk = 0 for new bit_idx 0..31 and 1 for 32..63. lr_clk, sd, and the shift register all update only on tick.
- Push: s_valid && s_ready writes the FIFO on that clk edge. s_data must be held until accepted.
- Load: occurs on the tick where bit_idx goes 0->1 (one-bit I2S delay).
  - FIFO non-empty: pop word w; shift register = {sext(w), sext(w)} (64 bits); sd = MSB of w.
  - FIFO empty: underrun pulses and the fallback word is sent (see Optional Feature).
- Other ticks: shift left one bit; sd = new MSB. The right-slot LSB is therefore driven during bit_idx 0 of the next frame.
- Simultaneous push and pop in the same cycle: both occur, count unchanged. Push while full is blocked because s_ready=0.
- Latency: a sample accepted into an empty FIFO appears on sd at the next load tick. Worst case is 64*CLK_PER_BIT + 1 clk.
- Async reset mid-frame: all outputs return to reset values immediately. Frame restarts at bit_idx 0, and the first load occurs at bit_idx 1.
- Arithmetic: sign extension only, no scaling or rounding.

Optional Feature:
- Macro: I2S_UNDERRUN_REPEAT_EN.
- Defined: on underrun, the last successfully popped sample (held in the last-sample register) is retransmitted.
- Undefined: on underrun, zeros are transmitted.
- underrun pulses in both builds.

Decomposition:
- supermic_pkg holds: I2S_SLOT_W=32, I2S_FRAME_BITS=64, and a sample typedef of IN_W bits.
- One sub-module: i2s_sample_fifo2, a 2-entry synchronous FIFO with count, full/empty, push/pop, and async active-low reset.
- Divider, bit counter, and shift register stay in i2s_frame_tx.

Test Plan (CLK_PER_BIT=4, so 256 clk per frame):
- Reset release with no input -> bclk toggles with period 4 clk; lr_clk period 256 clk; sd=0; underrun pulses once per frame at the bit_idx 0->1 tick.
- Push 22'h2AAAAA once -> next frame shows 32'hFFEAAAAA MSB-first in both slots, offset by one bclk after each lr_clk edge; s_ready stays 1.
- Push 3 samples back-to-back with no frames elapsed -> s_ready falls after the 2nd push; the 3rd is accepted after the next load tick; frames carry samples 1, 2, 3 in order.
- Push and load on the same clk with 1 entry stored -> count stays 1, no loss, no duplication.
- Underrun after 22'h000005: I2S_UNDERRUN_REPEAT_EN defined -> 32'h00000005 repeats; undefined -> zero frame; underrun=1 for exactly 1 clk.
- Assert rst mid-right-slot -> bclk, lr_clk, sd immediately 0, FIFO empty, s_ready=1; after release, first lr_clk rise occurs 128 clk later.

Source files
------------

// File: rtl/supermic_pkg.sv
// Shared constants and types for the SuperMic I2S output stage.
package supermic_pkg;

   localparam int I2S_SLOT_W     = 32;
   localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_W;
   localparam int I2S_IN_W       = 22;

   typedef logic signed [I2S_IN_W-1:0] sample_t;

   typedef enum logic {
      SLOT_LEFT  = 1'b0,
      SLOT_RIGHT = 1'b1
   } i2s_slot_e;

   // Which channel slot a frame bit position belongs to.
   function automatic i2s_slot_e slot_of(input int unsigned bit_idx, input int unsigned slot_w);
      return (bit_idx >= slot_w) ? SLOT_RIGHT : SLOT_LEFT;
   endfunction

endpackage

// File: rtl/i2s_sample_fifo2.sv
// Two-entry first-word-fall-through sample FIFO feeding the I2S serialiser.
module i2s_sample_fifo2
   import supermic_pkg::*;
#(
   parameter int W = I2S_IN_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push;
   logic         do_pop;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push && !do_pop)      count_d = count_q + 2'd1;
      else if (do_pop && !do_push) count_d = count_q - 2'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/i2s_frame_tx.sv
// Philips I2S transmitter: mono sample sent in both slots, sign-extended to SLOT_W.
// Build option I2S_UNDERRUN_REPEAT_EN: on underrun resend the last sample instead of zeros.
module i2s_frame_tx
   import supermic_pkg::*;
#(
   parameter int IN_W        = I2S_IN_W,
   parameter int SLOT_W      = I2S_SLOT_W,
   parameter int CLK_PER_BIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] s_data,
   input  logic            s_valid,
   output logic            s_ready,
   output logic            bclk,
   output logic            lr_clk,
   output logic            sd,
   output logic            frame_start,
   output logic            underrun
);

   localparam int FRAME_BITS = 2 * SLOT_W;
   localparam int CNT_W      = $clog2(CLK_PER_BIT);
   localparam int IDX_W      = $clog2(FRAME_BITS);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic                  lr_q, lr_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  frame_start_q, frame_start_d;
   logic                  underrun_q, underrun_d;
   logic                  tick;
   logic                  load;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [IN_W-1:0]       fifo_data;
   logic [IN_W-1:0]       fallback;
   logic [IN_W-1:0]       load_word;
   logic [SLOT_W-1:0]     slot_word;

   i2s_sample_fifo2 #(
      .W (IN_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (s_valid),
      .data_i  (s_data),
      .pop_i   (load),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // tick marks the bclk falling edge; the load sits one bit after the lr_clk edge.
   assign tick      = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
   assign load      = tick && (bit_idx_q == '0);
   assign s_ready   = !fifo_full;
   assign bclk      = (cnt_q >= CNT_W'(CLK_PER_BIT / 2));
   assign lr_clk    = lr_q;
   assign sd        = shift_q[FRAME_BITS-1];
   assign frame_start = frame_start_q;
   assign underrun  = underrun_q;

   assign load_word = fifo_empty ? fallback : fifo_data;
   assign slot_word = SLOT_W'($signed(load_word));

`ifdef I2S_UNDERRUN_REPEAT_EN
   logic [IN_W-1:0] last_q, last_d;

   assign fallback = last_q;

   always_comb begin
      last_d = last_q;
      if (load && !fifo_empty) last_d = fifo_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) last_q <= '0;
      else      last_q <= last_d;
   end
`else
   assign fallback = '0;
`endif

   always_comb begin
      cnt_d         = cnt_q + CNT_W'(1);
      bit_idx_d     = bit_idx_q;
      lr_d          = lr_q;
      shift_d       = shift_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      if (tick) begin
         cnt_d         = '0;
         bit_idx_d     = (bit_idx_q == IDX_W'(FRAME_BITS - 1)) ? '0 : bit_idx_q + IDX_W'(1);
         lr_d          = (slot_of(32'(bit_idx_d), 32'(SLOT_W)) == SLOT_RIGHT);
         frame_start_d = (bit_idx_q == IDX_W'(FRAME_BITS - 1));
         if (load) begin
            shift_d    = {slot_word, slot_word};
            underrun_d = fifo_empty;
         end else begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         lr_q          <= 1'b0;
         shift_q       <= '0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         lr_q          <= lr_d;
         shift_q       <= shift_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

endmodule
